ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction fetch stage sitting directly upstream of the cache controller.
- Drives `pc`/`start_fetch` into the controller and captures the returned `inst`/`inst_addr`.
- Statically predicts the next PC and buffers fetched instructions in a small FIFO toward the decoder.
- On `rob_clear_up` it flushes all state and restarts from `rob_new_pc`.

Parameters:
- DEPTH, 4, instruction queue entries; power of two, at least 2.
- RESET_PC, 32'h0, PC fetched first after reset.

Ports:
- clk_in  input  1  system clock; all state updates on its rising edge.
- rst_n_in  input  1  reset; asynchronous assertion, active-low.
- rdy_in  input  1  global ready; when low all state holds.
- rob_clear_up  input  1  pipeline flush (mispredict) from ROB.
- rob_new_pc  input  32  restart PC, valid with rob_clear_up.
- pc  output  32  fetch address to cache controller.
- start_fetch  output  1  fetch request; held with pc stable until accepted.
- fetch_ready  input  1  controller response valid (may be same-cycle on icache hit).
- inst  input  32  fetched instruction.
- inst_addr  input  32  address of returned instruction.
- dec_ready  input  1  decoder can accept this cycle.
- dec_valid  output  1  queue head valid.
- dec_inst  output  32  queue head instruction.
- dec_pc  output  32  queue head PC.
- dec_pred_pc  output  32  predicted next PC of head instruction.

Behaviour:
- Reset (rst_n_in=0, async):
  - pc=RESET_PC, start_fetch=0, queue empty (dec_valid=0), head/tail/count=0, FSM=IDLE.
  - dec_inst, dec_pc, dec_pred_pc read 0.
- FSM states IDLE and WAIT; start_fetch is a registered output, 1 exactly in WAIT.
  - IDLE -> WAIT when count<DEPTH.
  - WAIT: accept when fetch_ready && inst_addr==pc. A response with a mismatched inst_addr is discarded and the FSM stays in WAIT.
  - On accept, push {inst, pc, npc} and set pc<=npc. Stay in WAIT if count_after_push<DEPTH, else go to IDLE.
  - Back-to-back icache hits therefore sustain one instruction per cycle.
- Static prediction (npc), 32-bit RV32I instructions only:
  - opcode 1101111 (JAL): npc = pc + sign-extended J-imm.
  - opcode 1100011 (branch) with imm[12]=1 (backward): npc = pc + sign-extended B-imm.
  - All others, including forward branches and JALR: npc = pc+4.
  - Adds are modulo 2^32.
- Queue:
  - Circular buffer, pointers wrap modulo DEPTH, count width log2(DEPTH)+1.
  - dec_valid = count!=0; dec_* show the head entry combinationally.
  - Pop when dec_valid && dec_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop on empty is ignored. Push never occurs while full, because start_fetch is low.
- Flush (rob_clear_up=1 with rdy_in=1), overrides everything else in that cycle:
  - Queue emptied (pointers and count 0).
  - pc<=rob_new_pc, FSM<=IDLE, start_fetch<=0.
  - Any same-cycle fetch_ready is ignored and no pop is counted.
  - Next cycle: IDLE->WAIT with the new pc.
  - A late response for the old PC is dropped by the inst_addr check.
- rdy_in=0: no state changes, and outputs hold their registered values. A fetch_ready seen in that cycle is not accepted.
- Reset asserted mid-fetch: immediate return to reset values; the pending request is abandoned.

Test Plan:
- Reset release with RESET_PC=0 -> cycle 1 start_fetch=1, pc=0; until then dec_valid=0.
- Hits every cycle, dec_ready=0, DEPTH=4 -> entries pc 0,4,8,12 pushed on consecutive cycles. count=4 and start_fetch=0. Single pop -> start_fetch=1 next cycle, pc=16.
- inst=32'h0080006F (JAL x0,+8) at pc=0x100 -> dec_pred_pc=0x108, next pc=0x108. inst=32'hFE000EE3 (BEQ, imm -4) at 0x200 -> next pc=0x1FC. Forward BEQ at 0x300 -> next pc=0x304.
- Request in WAIT at pc=0x40, queue holding 2 entries, rob_clear_up=1 with rob_new_pc=0x800 and fetch_ready=1 the same cycle -> response dropped, dec_valid=0 next cycle, then pc=0x800 with start_fetch=1. A later fetch_ready with inst_addr=0x40 -> nothing pushed.
- rdy_in=0 for 3 cycles with fetch_ready=1 and dec_ready=1 -> pc, count and head unchanged. The fetch completes after rdy_in returns to 1.
- Simultaneous push and pop with count=2 -> count stays 2. Pointer wrap after 9 pushes and 9 pops -> FIFO order preserved (dec_pc sequence matches fetch order).

Source files
------------

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: fetch bus to the cache controller plus the decode-side queue head
interface ifetch_queue_if;
    logic [31:0] pc;
    logic        start_fetch;
    logic        fetch_ready;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic [31:0] dec_pred_pc;

    modport master (
        output pc, start_fetch, dec_valid, dec_inst, dec_pc, dec_pred_pc,
        input  fetch_ready, inst, inst_addr, dec_ready
    );

    modport slave (
        input  pc, start_fetch, dec_valid, dec_inst, dec_pc, dec_pred_pc,
        output fetch_ready, inst, inst_addr, dec_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch FSM with static next-PC prediction feeding a small instruction FIFO
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           rdy_in,
    input  logic           rob_clear_up,
    input  logic [31:0]    rob_new_pc,
    ifetch_queue_if.master bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        r_state;
    logic          r_start;
    logic [31:0]   r_pc;
    logic [AW-1:0] r_head, r_tail;
    logic [AW:0]   r_count;
    logic [31:0]   r_q_inst [DEPTH];
    logic [31:0]   r_q_pc   [DEPTH];
    logic [31:0]   r_q_pred [DEPTH];

    logic [6:0]    w_opcode;
    logic [31:0]   w_j_imm, w_b_imm, w_npc;
    logic          w_accept, w_pop, w_valid;
    logic [AW:0]   w_count_next;

    // Static prediction: JAL and backward branches taken, everything else falls through
    assign w_opcode = bus.inst[6:0];
    assign w_j_imm  = {{12{bus.inst[31]}}, bus.inst[19:12], bus.inst[20], bus.inst[30:21], 1'b0};
    assign w_b_imm  = {{20{bus.inst[31]}}, bus.inst[7], bus.inst[30:25], bus.inst[11:8], 1'b0};
    assign w_npc    = r_pc + ((w_opcode == 7'b1101111) ? w_j_imm :
                              (w_opcode == 7'b1100011 && bus.inst[31]) ? w_b_imm : 32'd4);

    // A response only counts if it answers the address currently requested
    assign w_valid  = r_count != '0;
    assign w_accept = rdy_in && !rob_clear_up && r_state == S_WAIT && bus.fetch_ready && bus.inst_addr == r_pc;
    assign w_pop    = rdy_in && !rob_clear_up && w_valid && bus.dec_ready;
    assign w_count_next = (w_accept && !w_pop) ? r_count + (AW+1)'(1) :
                          (!w_accept && w_pop) ? r_count - (AW+1)'(1) : r_count;

    assign bus.pc          = r_pc;
    assign bus.start_fetch = r_start;
    assign bus.dec_valid   = w_valid;
    assign bus.dec_inst    = w_valid ? r_q_inst[r_head] : '0;
    assign bus.dec_pc      = w_valid ? r_q_pc[r_head]   : '0;
    assign bus.dec_pred_pc = w_valid ? r_q_pred[r_head] : '0;

    // Fetch FSM: request while the queue has room, advance pc on each accepted response
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
            r_pc    <= RESET_PC;
        end else if (rdy_in) begin
            if (rob_clear_up) begin
                r_state <= S_IDLE;
                r_start <= 1'b0;
                r_pc    <= rob_new_pc;
            end else if (r_state == S_IDLE) begin
                if (r_count < FULL) begin
                    r_state <= S_WAIT;
                    r_start <= 1'b1;
                end
            end else if (w_accept) begin
                r_pc <= w_npc;
                if (w_count_next == FULL) begin
                    r_state <= S_IDLE;
                    r_start <= 1'b0;
                end
            end
        end
    end

    // Queue pointers and occupancy; a flush empties the queue outright
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (rob_clear_up) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_accept) r_tail <= r_tail + AW'(1);
                if (w_pop)    r_head <= r_head + AW'(1);
                r_count <= w_count_next;
            end
        end
    end

    // Queue storage; entries are only ever read while counted as valid
    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_q_inst[r_tail] <= bus.inst;
            r_q_pc[r_tail]   <= r_pc;
            r_q_pred[r_tail] <= w_npc;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed vector table plus hand-written flush, stall, wrap and reset sequences
module tb_ifetch_queue;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] JAL8  = 32'h0080006F;
    localparam logic [31:0] BEQM4 = 32'hFE000EE3;
    localparam logic [31:0] BEQP8 = 32'h00000463;
    localparam logic [31:0] JALR  = 32'h000000E7;
    localparam logic [31:0] ADDI  = 32'h00100093;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        rob_clear_up = 1'b0;
    logic [31:0] rob_new_pc = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    ifetch_queue_if bus ();

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .rdy_in       (rdy_in),
        .rob_clear_up (rob_clear_up),
        .rob_new_pc   (rob_new_pc),
        .bus          (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy, clr;
        logic [31:0] npc;
        logic        fr;
        logic [31:0] inst, iaddr;
        logic        drdy;
        logic [31:0] e_pc;
        logic        e_start, e_valid;
        logic [31:0] e_dpc, e_pred;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic clr, input logic [31:0] npc, input logic fr,
                         input logic [31:0] inst, input logic [31:0] iaddr, input logic drdy);
        rdy_in = rdy;
        rob_clear_up = clr;
        rob_new_pc = npc;
        bus.fetch_ready = fr;
        bus.inst = inst;
        bus.inst_addr = iaddr;
        bus.dec_ready = drdy;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [31:0] pc, input logic start, input logic valid,
                           input logic [31:0] dpc);
        chk({nm, ".pc"}, bus.pc, pc);
        chk({nm, ".start"}, 32'(bus.start_fetch), 32'(start));
        chk({nm, ".valid"}, 32'(bus.dec_valid), 32'(valid));
        if (valid) chk({nm, ".dpc"}, bus.dec_pc, dpc);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, ".pc"}, bus.pc, 32'h0);
        chk({nm, ".start"}, 32'(bus.start_fetch), 32'h0);
        chk({nm, ".valid"}, 32'(bus.dec_valid), 32'h0);
        chk({nm, ".inst"}, bus.dec_inst, 32'h0);
        chk({nm, ".dpc"}, bus.dec_pc, 32'h0);
        chk({nm, ".pred"}, bus.dec_pred_pc, 32'h0);
    endtask

    initial begin
        //               rdy clr npc      fr inst   iaddr     drdy  pc       st vl dpc      pred
        tbl.push_back('{1, 0, 0,        0, NOP,   0,        0,    0,       1, 0, 0,       0});
        tbl.push_back('{1, 0, 0,        1, NOP,   0,        0,    4,       1, 1, 0,       4});
        tbl.push_back('{1, 0, 0,        1, NOP,   4,        0,    8,       1, 1, 0,       4});
        tbl.push_back('{1, 0, 0,        1, NOP,   8,        0,    12,      1, 1, 0,       4});
        tbl.push_back('{1, 0, 0,        1, NOP,   12,       0,    16,      0, 1, 0,       4});
        tbl.push_back('{1, 0, 0,        1, NOP,   16,       1,    16,      0, 1, 4,       8});
        tbl.push_back('{1, 0, 0,        0, NOP,   0,        0,    16,      1, 1, 4,       8});
        tbl.push_back('{1, 0, 0,        1, NOP,   16,       1,    20,      1, 1, 8,       12});
        tbl.push_back('{1, 0, 0,        1, NOP,   32'h999,  0,    20,      1, 1, 8,       12});
        tbl.push_back('{1, 0, 0,        0, NOP,   0,        1,    20,      1, 1, 12,      16});
        tbl.push_back('{1, 0, 0,        0, NOP,   0,        1,    20,      1, 1, 16,      20});
        tbl.push_back('{1, 0, 0,        0, NOP,   0,        1,    20,      1, 0, 0,       0});
        tbl.push_back('{1, 1, 32'h100,  0, NOP,   0,        0,    32'h100, 0, 0, 0,       0});
        tbl.push_back('{1, 0, 0,        0, NOP,   0,        0,    32'h100, 1, 0, 0,       0});
        tbl.push_back('{1, 0, 0,        1, JAL8,  32'h100,  0,    32'h108, 1, 1, 32'h100, 32'h108});
        tbl.push_back('{1, 1, 32'h200,  1, NOP,   32'h108,  1,    32'h200, 0, 0, 0,       0});
        tbl.push_back('{1, 0, 0,        0, NOP,   0,        0,    32'h200, 1, 0, 0,       0});
        tbl.push_back('{1, 0, 0,        1, BEQM4, 32'h200,  0,    32'h1FC, 1, 1, 32'h200, 32'h1FC});
        tbl.push_back('{1, 1, 32'h300,  0, NOP,   0,        0,    32'h300, 0, 0, 0,       0});
        tbl.push_back('{1, 0, 0,        0, NOP,   0,        0,    32'h300, 1, 0, 0,       0});
        tbl.push_back('{1, 0, 0,        1, BEQP8, 32'h300,  0,    32'h304, 1, 1, 32'h300, 32'h304});
        tbl.push_back('{1, 0, 0,        1, JALR,  32'h304,  0,    32'h308, 1, 1, 32'h300, 32'h304});

        drive(1, 0, 0, 0, NOP, 0, 0);
        #12;
        chk_reset("reset");
        rst_n_in = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rdy, tbl[i].clr, tbl[i].npc, tbl[i].fr, tbl[i].inst, tbl[i].iaddr, tbl[i].drdy);
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_start, tbl[i].e_valid, tbl[i].e_dpc);
            if (tbl[i].e_valid) chk($sformatf("vec%0d.pred", i), bus.dec_pred_pc, tbl[i].e_pred);
        end

        // Flush while a request for 0x40 is pending with two entries queued
        drive(1, 1, 32'h38, 0, NOP, 0, 0);     tick(); chk_out("fl.a", 32'h38, 0, 0, 0);
        drive(1, 0, 0, 0, NOP, 0, 0);          tick(); chk_out("fl.b", 32'h38, 1, 0, 0);
        drive(1, 0, 0, 1, NOP, 32'h38, 0);     tick(); chk_out("fl.c", 32'h3C, 1, 1, 32'h38);
        drive(1, 0, 0, 1, NOP, 32'h3C, 0);     tick(); chk_out("fl.d", 32'h40, 1, 1, 32'h38);
        drive(1, 1, 32'h800, 1, NOP, 32'h40, 0); tick(); chk_out("fl.e", 32'h800, 0, 0, 0);
        drive(1, 0, 0, 1, NOP, 32'h40, 0);     tick(); chk_out("fl.f", 32'h800, 1, 0, 0);
        drive(1, 0, 0, 1, NOP, 32'h40, 0);     tick(); chk_out("fl.g", 32'h800, 1, 0, 0);

        // Global stall: nothing moves while rdy_in is low, fetch completes afterwards
        drive(1, 0, 0, 1, ADDI, 32'h800, 0);   tick(); chk_out("st.a", 32'h804, 1, 1, 32'h800);
        chk("st.a.inst", bus.dec_inst, ADDI);
        chk("st.a.pred", bus.dec_pred_pc, 32'h804);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, NOP, 32'h804, 1);
            tick();
            chk_out($sformatf("st.hold%0d", i), 32'h804, 1, 1, 32'h800);
        end
        drive(1, 0, 0, 1, NOP, 32'h804, 0);    tick(); chk_out("st.b", 32'h808, 1, 1, 32'h800);
        drive(1, 0, 0, 0, NOP, 0, 1);          tick(); chk_out("st.c", 32'h808, 1, 1, 32'h804);
        drive(1, 0, 0, 0, NOP, 0, 1);          tick(); chk_out("st.d", 32'h808, 1, 0, 0);

        // Nine pushes and nine pops across the pointer wrap, with steady push+pop at two entries
        drive(1, 1, 32'h1000, 0, NOP, 0, 0);   tick(); chk_out("wr.fl", 32'h1000, 0, 0, 0);
        drive(1, 0, 0, 0, NOP, 0, 0);          tick(); chk_out("wr.go", 32'h1000, 1, 0, 0);
        for (int k = 0; k < 9; k++) begin
            drive(1, 0, 0, 1, NOP, 32'h1000 + 32'(4 * k), k >= 2);
            tick();
            chk_out($sformatf("wr%0d", k), 32'h1000 + 32'(4 * (k + 1)), 1, 1,
                    (k < 2) ? 32'h1000 : 32'h1000 + 32'(4 * (k - 1)));
        end
        drive(1, 0, 0, 0, NOP, 0, 1);          tick(); chk_out("wr.d1", 32'h1024, 1, 1, 32'h1020);
        drive(1, 0, 0, 0, NOP, 0, 1);          tick(); chk_out("wr.d2", 32'h1024, 1, 0, 0);

        // Asynchronous reset in the middle of a pending fetch
        drive(1, 0, 0, 1, NOP, 32'h1024, 0);
        #3;
        rst_n_in = 1'b0;
        #1;
        chk_reset("arst");
        tick();
        chk_reset("arst.held");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
